// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush squash and hold freeze.
// Optional perf counters (bubbles/flushes) enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_stage #(
   parameter int DATA_W = 16,
   parameter int REG_AW = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid,
   input  logic              id_alu_src,
   input  logic              id_mem_to_reg,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              id_mem_write,
   input  logic              id_for_loop,
   input  logic [2:0]        id_branch,
   input  logic [3:0]        id_alu_op,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic [REG_AW-1:0] id_dest,
   input  logic              id_rs_used,
   input  logic              id_rt_used,
   input  logic [DATA_W-1:0] id_rs_data,
   input  logic [DATA_W-1:0] id_rt_data,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [DATA_W-1:0] id_pc1,
   input  logic              ex_flush,
   input  logic              ex_hold,
   output logic              stall_id,
   output logic              ex_valid,
   output logic              ex_alu_src,
   output logic              ex_mem_to_reg,
   output logic              ex_reg_write,
   output logic              ex_mem_read,
   output logic              ex_mem_write,
   output logic              ex_for_loop,
   output logic [2:0]        ex_branch,
   output logic [3:0]        ex_alu_op,
   output logic [REG_AW-1:0] ex_rs,
   output logic [REG_AW-1:0] ex_rt,
   output logic [REG_AW-1:0] ex_dest,
   output logic [DATA_W-1:0] ex_rs_data,
   output logic [DATA_W-1:0] ex_rt_data,
   output logic [DATA_W-1:0] ex_imm,
   output logic [DATA_W-1:0] ex_pc1
`ifdef ID_EX_PERF_CNT_EN
   ,
   output logic [15:0]       perf_bubbles,
   output logic [15:0]       perf_flushes
`endif
);

   localparam int CTRL_W = 13;

   logic [CTRL_W-1:0] id_ctrl, ctrl_d, ctrl_q;
   logic              valid_d, valid_q;
   logic [REG_AW-1:0] rs_d, rs_q, rt_d, rt_q, dest_d, dest_q;
   logic [DATA_W-1:0] rs_data_d, rs_data_q, rt_data_d, rt_data_q;
   logic [DATA_W-1:0] imm_d, imm_q, pc1_d, pc1_q;
   logic              hz, load_bubble, load_id;

   assign id_ctrl = {id_alu_src, id_mem_to_reg, id_reg_write, id_mem_read,
                     id_mem_write, id_for_loop, id_branch, id_alu_op};

   assign {ex_alu_src, ex_mem_to_reg, ex_reg_write, ex_mem_read,
           ex_mem_write, ex_for_loop, ex_branch, ex_alu_op} = ctrl_q;
   assign ex_valid   = valid_q;
   assign ex_rs      = rs_q;
   assign ex_rt      = rt_q;
   assign ex_dest    = dest_q;
   assign ex_rs_data = rs_data_q;
   assign ex_rt_data = rt_data_q;
   assign ex_imm     = imm_q;
   assign ex_pc1     = pc1_q;

   // r0 is compared like any other register; decode never forwards from it here.
   assign hz = id_valid & valid_q & ex_mem_read &
               ((id_rs_used & (id_rs == dest_q)) | (id_rt_used & (id_rt == dest_q)));

   assign stall_id    = (hz | ex_hold) & ~ex_flush;
   assign load_bubble = ex_flush | (~ex_hold & hz);
   assign load_id     = ~ex_flush & ~ex_hold & ~hz;

   always_comb begin
      valid_d   = valid_q;
      ctrl_d    = ctrl_q;
      rs_d      = rs_q;
      rt_d      = rt_q;
      dest_d    = dest_q;
      rs_data_d = rs_data_q;
      rt_data_d = rt_data_q;
      imm_d     = imm_q;
      pc1_d     = pc1_q;
      if (load_bubble) begin
         valid_d   = 1'b0;
         ctrl_d    = '0;
         rs_d      = '0;
         rt_d      = '0;
         dest_d    = '0;
         rs_data_d = '0;
         rt_data_d = '0;
         imm_d     = '0;
         pc1_d     = '0;
      end else if (load_id) begin
         valid_d   = id_valid;
         ctrl_d    = id_valid ? id_ctrl : '0;
         rs_d      = id_rs;
         rt_d      = id_rt;
         dest_d    = id_dest;
         rs_data_d = id_rs_data;
         rt_data_d = id_rt_data;
         imm_d     = id_imm;
         pc1_d     = id_pc1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q   <= 1'b0;
         ctrl_q    <= '0;
         rs_q      <= '0;
         rt_q      <= '0;
         dest_q    <= '0;
         rs_data_q <= '0;
         rt_data_q <= '0;
         imm_q     <= '0;
         pc1_q     <= '0;
      end else begin
         valid_q   <= valid_d;
         ctrl_q    <= ctrl_d;
         rs_q      <= rs_d;
         rt_q      <= rt_d;
         dest_q    <= dest_d;
         rs_data_q <= rs_data_d;
         rt_data_q <= rt_data_d;
         imm_q     <= imm_d;
         pc1_q     <= pc1_d;
      end
   end

`ifdef ID_EX_PERF_CNT_EN
   logic [15:0] bub_cnt_q, flush_cnt_q;

   // Bubble count only when the hazard itself won; hold-frozen cycles are not bubbles.
   always_ff @(posedge clk) begin
      if (reset) begin
         bub_cnt_q   <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (~ex_flush & ~ex_hold & hz & (bub_cnt_q != 16'hFFFF))
            bub_cnt_q <= bub_cnt_q + 16'd1;
         if (ex_flush & (flush_cnt_q != 16'hFFFF))
            flush_cnt_q <= flush_cnt_q + 16'd1;
      end
   end

   assign perf_bubbles = bub_cnt_q;
   assign perf_flushes = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, randomized run against a reference model,
// and a perf-counter sequence when ID_EX_PERF_CNT_EN is defined.
module tb_id_ex_stage;

   typedef struct packed {
      logic        valid, alu_src, m2r, rw, mr, mw, fl;
      logic [2:0]  branch;
      logic [3:0]  alu_op;
      logic [2:0]  rs, rt, dest;
      logic        rs_used, rt_used;
      logic [15:0] rs_data, rt_data, imm, pc1;
   } id_in_t;

   typedef struct packed {
      logic        valid, alu_src, m2r, rw, mr, mw, fl;
      logic [2:0]  branch;
      logic [3:0]  alu_op;
      logic [2:0]  rs, rt, dest;
      logic [15:0] rs_data, rt_data, imm, pc1;
   } ex_t;

   typedef struct {
      id_in_t      id;
      logic        rst, flush, hold, chk_stall, stall;
      logic        valid, rw, mr, mw;
      logic [3:0]  alu_op;
      logic [2:0]  dest;
      logic [15:0] rs_data, imm;
   } vec_t;

   logic        clk, reset;
   logic        id_valid, id_alu_src, id_mem_to_reg, id_reg_write, id_mem_read, id_mem_write, id_for_loop;
   logic [2:0]  id_branch;
   logic [3:0]  id_alu_op;
   logic [2:0]  id_rs, id_rt, id_dest;
   logic        id_rs_used, id_rt_used;
   logic [15:0] id_rs_data, id_rt_data, id_imm, id_pc1;
   logic        ex_flush, ex_hold, stall_id;
   logic        ex_valid, ex_alu_src, ex_mem_to_reg, ex_reg_write, ex_mem_read, ex_mem_write, ex_for_loop;
   logic [2:0]  ex_branch;
   logic [3:0]  ex_alu_op;
   logic [2:0]  ex_rs, ex_rt, ex_dest;
   logic [15:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc1;
`ifdef ID_EX_PERF_CNT_EN
   logic [15:0] perf_bubbles, perf_flushes;
`endif

   int n_pass = 0;
   int n_total = 0;

   id_ex_stage #(.DATA_W(16), .REG_AW(3)) dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_alu_src(id_alu_src),
      .id_mem_to_reg(id_mem_to_reg), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .id_mem_write(id_mem_write), .id_for_loop(id_for_loop), .id_branch(id_branch),
      .id_alu_op(id_alu_op), .id_rs(id_rs), .id_rt(id_rt), .id_dest(id_dest),
      .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rs_data(id_rs_data),
      .id_rt_data(id_rt_data), .id_imm(id_imm), .id_pc1(id_pc1), .ex_flush(ex_flush),
      .ex_hold(ex_hold), .stall_id(stall_id), .ex_valid(ex_valid), .ex_alu_src(ex_alu_src),
      .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .ex_for_loop(ex_for_loop), .ex_branch(ex_branch),
      .ex_alu_op(ex_alu_op), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest),
      .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_pc1(ex_pc1)
`ifdef ID_EX_PERF_CNT_EN
      , .perf_bubbles(perf_bubbles), .perf_flushes(perf_flushes)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic apply(input id_in_t v, input logic r, input logic f, input logic h);
      id_valid = v.valid;  id_alu_src = v.alu_src; id_mem_to_reg = v.m2r;
      id_reg_write = v.rw; id_mem_read = v.mr;      id_mem_write = v.mw;
      id_for_loop = v.fl;  id_branch = v.branch;    id_alu_op = v.alu_op;
      id_rs = v.rs; id_rt = v.rt; id_dest = v.dest;
      id_rs_used = v.rs_used; id_rt_used = v.rt_used;
      id_rs_data = v.rs_data; id_rt_data = v.rt_data; id_imm = v.imm; id_pc1 = v.pc1;
      reset = r; ex_flush = f; ex_hold = h;
   endtask

   function automatic ex_t read_ex();
      ex_t e;
      e.valid = ex_valid; e.alu_src = ex_alu_src; e.m2r = ex_mem_to_reg; e.rw = ex_reg_write;
      e.mr = ex_mem_read; e.mw = ex_mem_write; e.fl = ex_for_loop; e.branch = ex_branch;
      e.alu_op = ex_alu_op; e.rs = ex_rs; e.rt = ex_rt; e.dest = ex_dest;
      e.rs_data = ex_rs_data; e.rt_data = ex_rt_data; e.imm = ex_imm; e.pc1 = ex_pc1;
      return e;
   endfunction

   function automatic id_in_t ins(input logic v, input logic alu_src, input logic m2r,
                                  input logic rw, input logic mr, input logic mw,
                                  input logic [3:0] op, input logic [2:0] rs, input logic [2:0] rt,
                                  input logic [2:0] dest, input logic rsu, input logic rtu,
                                  input logic [15:0] rsd, input logic [15:0] imm);
      id_in_t i;
      i.valid = v; i.alu_src = alu_src; i.m2r = m2r; i.rw = rw; i.mr = mr; i.mw = mw;
      i.fl = 1'b0; i.branch = 3'b000; i.alu_op = op; i.rs = rs; i.rt = rt; i.dest = dest;
      i.rs_used = rsu; i.rt_used = rtu; i.rs_data = rsd; i.rt_data = rsd ^ 16'h00FF;
      i.imm = imm; i.pc1 = imm + 16'h0100;
      return i;
   endfunction

   function automatic vec_t row(input id_in_t id, input logic rst, input logic flush, input logic hold,
                                input logic chk, input logic stall, input logic valid, input logic rw,
                                input logic mr, input logic mw, input logic [3:0] op,
                                input logic [2:0] dest, input logic [15:0] rsd, input logic [15:0] imm);
      vec_t r;
      r.id = id; r.rst = rst; r.flush = flush; r.hold = hold; r.chk_stall = chk; r.stall = stall;
      r.valid = valid; r.rw = rw; r.mr = mr; r.mw = mw; r.alu_op = op; r.dest = dest;
      r.rs_data = rsd; r.imm = imm;
      return r;
   endfunction

   // Reference: what EX should hold after the edge, from the stage's priority rules.
   function automatic ex_t model_next(input ex_t m, input id_in_t v, input logic r, input logic f,
                                      input logic h, output logic stall);
      logic hz;
      ex_t n;
      hz = v.valid && m.valid && m.mr &&
           ((v.rs_used && v.rs == m.dest) || (v.rt_used && v.rt == m.dest));
      stall = (hz || h) && !f;
      n = m;
      if (r || f || (!h && hz)) n = '0;
      else if (!h) begin
         n = '0;
         n.valid = v.valid; n.rs = v.rs; n.rt = v.rt; n.dest = v.dest;
         n.rs_data = v.rs_data; n.rt_data = v.rt_data; n.imm = v.imm; n.pc1 = v.pc1;
         if (v.valid) begin
            n.alu_src = v.alu_src; n.m2r = v.m2r; n.rw = v.rw; n.mr = v.mr; n.mw = v.mw;
            n.fl = v.fl; n.branch = v.branch; n.alu_op = v.alu_op;
         end
      end
      return n;
   endfunction

   vec_t   vec[22];
   id_in_t full_i, addi_i, lw_i, rdep_i, rnou_i, swd_i, a_i, b_i, b1_i, b2_i, inv_i;

   initial begin
      full_i = ins(1,1,1,1,1,1,4'hF,7,7,7,1,1,16'hFFFF,16'hFFFF);
      full_i.fl = 1'b1; full_i.branch = 3'b111;
      addi_i = ins(1,1,0,1,0,0,4'd5,1,0,2,1,0,16'h1234,16'h0005);
      lw_i   = ins(1,1,1,1,1,0,4'd2,1,0,3,1,0,16'h0010,16'h0004);
      rdep_i = ins(1,0,0,1,0,0,4'd0,3,4,5,1,1,16'h0AAA,16'h0000);
      rnou_i = ins(1,0,0,1,0,0,4'd0,3,4,5,0,1,16'h0CCC,16'h0000);
      swd_i  = ins(1,1,0,0,0,1,4'd2,3,6,0,1,1,16'h0BBB,16'h0008);
      a_i    = ins(1,1,0,1,0,0,4'd5,0,0,1,1,0,16'h1111,16'h0001);
      b_i    = ins(1,1,0,1,0,0,4'd5,2,0,6,1,0,16'h2222,16'h0002);
      b1_i   = ins(1,1,0,1,0,0,4'd5,2,0,7,1,0,16'h3333,16'h0003);
      b2_i   = ins(1,0,1,1,1,0,4'd2,2,0,4,1,0,16'h5555,16'h0006);
      inv_i  = ins(0,1,1,1,1,1,4'd7,1,1,4,1,1,16'h4444,16'h0009);

      //            id      rst f h chk st   v rw mr mw op    dest rs_data   imm
      vec[0]  = row(full_i, 1, 0,0, 0, 0,   0,0, 0, 0, 4'd0, 0, 16'h0000, 16'h0000);
      vec[1]  = row(addi_i, 0, 0,0, 1, 0,   1,1, 0, 0, 4'd5, 2, 16'h1234, 16'h0005);
      vec[2]  = row(lw_i,   0, 0,0, 1, 0,   1,1, 1, 0, 4'd2, 3, 16'h0010, 16'h0004);
      vec[3]  = row(rdep_i, 0, 0,0, 1, 1,   0,0, 0, 0, 4'd0, 0, 16'h0000, 16'h0000);
      vec[4]  = row(rdep_i, 0, 0,0, 1, 0,   1,1, 0, 0, 4'd0, 5, 16'h0AAA, 16'h0000);
      vec[5]  = row(lw_i,   0, 0,0, 1, 0,   1,1, 1, 0, 4'd2, 3, 16'h0010, 16'h0004);
      vec[6]  = row(rnou_i, 0, 0,0, 1, 0,   1,1, 0, 0, 4'd0, 5, 16'h0CCC, 16'h0000);
      vec[7]  = row(lw_i,   0, 0,0, 1, 0,   1,1, 1, 0, 4'd2, 3, 16'h0010, 16'h0004);
      vec[8]  = row(swd_i,  0, 1,1, 1, 0,   0,0, 0, 0, 4'd0, 0, 16'h0000, 16'h0000);
      vec[9]  = row(a_i,    0, 0,0, 1, 0,   1,1, 0, 0, 4'd5, 1, 16'h1111, 16'h0001);
      vec[10] = row(b1_i,   0, 0,1, 1, 1,   1,1, 0, 0, 4'd5, 1, 16'h1111, 16'h0001);
      vec[11] = row(b2_i,   0, 0,1, 1, 1,   1,1, 0, 0, 4'd5, 1, 16'h1111, 16'h0001);
      vec[12] = row(b_i,    0, 0,1, 1, 1,   1,1, 0, 0, 4'd5, 1, 16'h1111, 16'h0001);
      vec[13] = row(b_i,    0, 0,0, 1, 0,   1,1, 0, 0, 4'd5, 6, 16'h2222, 16'h0002);
      vec[14] = row(lw_i,   0, 0,0, 1, 0,   1,1, 1, 0, 4'd2, 3, 16'h0010, 16'h0004);
      vec[15] = row(rdep_i, 0, 0,1, 1, 1,   1,1, 1, 0, 4'd2, 3, 16'h0010, 16'h0004);
      vec[16] = row(rdep_i, 0, 0,0, 1, 1,   0,0, 0, 0, 4'd0, 0, 16'h0000, 16'h0000);
      vec[17] = row(rdep_i, 0, 0,0, 1, 0,   1,1, 0, 0, 4'd0, 5, 16'h0AAA, 16'h0000);
      vec[18] = row(lw_i,   0, 0,0, 1, 0,   1,1, 1, 0, 4'd2, 3, 16'h0010, 16'h0004);
      vec[19] = row(rdep_i, 1, 0,0, 1, 1,   0,0, 0, 0, 4'd0, 0, 16'h0000, 16'h0000);
      vec[20] = row(rdep_i, 0, 0,0, 1, 0,   1,1, 0, 0, 4'd0, 5, 16'h0AAA, 16'h0000);
      vec[21] = row(inv_i,  0, 0,0, 1, 0,   0,0, 0, 0, 4'd0, 4, 16'h4444, 16'h0009);

      for (int i = 0; i < 22; i++) begin
         apply(vec[i].id, vec[i].rst, vec[i].flush, vec[i].hold);
         #1;
         if (vec[i].chk_stall) check($sformatf("vec%0d stall_id", i), 128'(stall_id), 128'(vec[i].stall));
         @(posedge clk);
         #1;
         check($sformatf("vec%0d ex", i),
               128'({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_op, ex_dest, ex_rs_data, ex_imm}),
               128'({vec[i].valid, vec[i].rw, vec[i].mr, vec[i].mw, vec[i].alu_op, vec[i].dest,
                     vec[i].rs_data, vec[i].imm}));
      end

      begin
         ex_t    m, n;
         id_in_t v;
         logic   r, f, h, st;
         m = '0;
         for (int i = 0; i < 400; i++) begin
            v.valid = 1'($urandom_range(0, 3) != 0);
            v.alu_src = 1'($urandom_range(0, 1)); v.m2r = 1'($urandom_range(0, 1));
            v.rw = 1'($urandom_range(0, 1));      v.mr = 1'($urandom_range(0, 1));
            v.mw = 1'($urandom_range(0, 1));      v.fl = 1'($urandom_range(0, 1));
            v.branch = 3'($urandom_range(0, 7));  v.alu_op = 4'($urandom_range(0, 15));
            v.rs = 3'($urandom_range(0, 3));      v.rt = 3'($urandom_range(0, 3));
            v.dest = 3'($urandom_range(0, 3));
            v.rs_used = 1'($urandom_range(0, 1)); v.rt_used = 1'($urandom_range(0, 1));
            v.rs_data = 16'($urandom); v.rt_data = 16'($urandom);
            v.imm = 16'($urandom);     v.pc1 = 16'($urandom);
            r = (i == 0) || ($urandom_range(0, 31) == 0);
            f = ($urandom_range(0, 7) == 0);
            h = ($urandom_range(0, 4) == 0);
            apply(v, r, f, h);
            n = model_next(m, v, r, f, h, st);
            #1;
            if (i > 0) check($sformatf("rand%0d stall_id", i), 128'(stall_id), 128'(st));
            @(posedge clk);
            #1;
            m = n;
            check($sformatf("rand%0d ex", i), 128'(read_ex()), 128'(m));
         end
      end

`ifdef ID_EX_PERF_CNT_EN
      begin
         id_in_t seq_id[9];
         logic   seq_r[9], seq_f[9], seq_h[9];
         seq_id = '{full_i, lw_i, rdep_i, rdep_i, lw_i, rdep_i, rdep_i, rdep_i, swd_i};
         seq_r  = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
         seq_f  = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
         seq_h  = '{0, 0, 0, 0, 0, 1, 0, 0, 1};
         for (int i = 0; i < 9; i++) begin
            apply(seq_id[i], seq_r[i], seq_f[i], seq_h[i]);
            @(posedge clk);
            #1;
         end
         check("perf_bubbles", 128'(perf_bubbles), 128'(16'd2));
         check("perf_flushes", 128'(perf_flushes), 128'(16'd1));
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
